// File: rtl/div_ctrl_if.sv
// ============================================================================
// Module  : div_ctrl_if
// Brief   : Request, divider and writeback signals of div_ctrl in one bundle.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface div_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_dividend;
    logic [31:0] req_divisor;
    logic [1:0]  req_mode;
    logic [4:0]  req_rd;
    logic        flush;

    logic        div_start;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [1:0]  div_mode;
    logic [31:0] div_result;
    logic        div_done;

    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy;

    // Controller side
    modport slave (
        input  req_valid, req_dividend, req_divisor, req_mode, req_rd, flush,
        input  div_result, div_done, wb_ready,
        output req_ready, div_start, div_dividend, div_divisor, div_mode,
        output wb_valid, wb_rd, wb_data, busy
    );

    // Execute stage / divider / writeback side
    modport master (
        output req_valid, req_dividend, req_divisor, req_mode, req_rd, flush,
        output div_result, div_done, wb_ready,
        input  req_ready, div_start, div_dividend, div_divisor, div_mode,
        input  wb_valid, wb_rd, wb_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
// Module  : div_ctrl
// Brief   : Sequencer between execute stage and radix-2 divider; optional
//           one-entry result cache under DIV_CTRL_RESULT_CACHE_EN.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module div_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    div_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_dividend;
    logic [31:0] r_divisor;
    logic [1:0]  r_mode;
    logic [4:0]  r_rd;
    logic        r_start;
    logic [31:0] r_wb_data;

    logic        w_accept;
    logic        w_capture;
    logic        w_start_nxt;
    logic        w_hit_load;
    logic        w_hit;
    logic [31:0] w_hit_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        w_start_nxt = 1'b0;
        w_hit_load  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    w_accept = 1'b1;
                    if (w_hit) begin
                        w_state_nxt = S_WB;
                        w_hit_load  = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                        w_start_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (bus.div_done && !bus.flush) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_WB;
                end else if (bus.flush) begin
                    // The divider cannot be aborted; wait out its done pulse
                    w_state_nxt = bus.div_done ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (bus.div_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WB: begin
                if (bus.wb_ready || bus.flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= 32'd0;
            r_divisor  <= 32'd0;
            r_mode     <= 2'd0;
            r_rd       <= 5'd0;
            r_start    <= 1'b0;
            r_wb_data  <= 32'd0;
        end else begin
            r_start <= w_start_nxt;
            if (w_accept) begin
                r_dividend <= bus.req_dividend;
                r_divisor  <= bus.req_divisor;
                r_mode     <= bus.req_mode;
                r_rd       <= bus.req_rd;
            end
            if (w_capture) begin
                r_wb_data <= bus.div_result;
            end else if (w_hit_load) begin
                r_wb_data <= w_hit_data;
            end
        end
    end

`ifdef DIV_CTRL_RESULT_CACHE_EN
    logic [31:0] r_c_dividend;
    logic [31:0] r_c_divisor;
    logic [1:0]  r_c_mode;
    logic [31:0] r_c_result;
    logic        r_c_valid;

    // Flushed results are still valid divisions, so they are cached too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_dividend <= 32'd0;
            r_c_divisor  <= 32'd0;
            r_c_mode     <= 2'd0;
            r_c_result   <= 32'd0;
            r_c_valid    <= 1'b0;
        end else if (((r_state == S_RUN) || (r_state == S_DRAIN)) && bus.div_done) begin
            r_c_dividend <= r_dividend;
            r_c_divisor  <= r_divisor;
            r_c_mode     <= r_mode;
            r_c_result   <= bus.div_result;
            r_c_valid    <= 1'b1;
        end
    end

    assign w_hit      = r_c_valid
                        && (r_c_dividend == bus.req_dividend)
                        && (r_c_divisor  == bus.req_divisor)
                        && (r_c_mode     == bus.req_mode);
    assign w_hit_data = r_c_result;
`else
    assign w_hit      = 1'b0;
    assign w_hit_data = 32'd0;
`endif

    assign bus.req_ready    = (r_state == S_IDLE);
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.div_start    = r_start;
    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
    assign bus.div_mode     = r_mode;
    assign bus.wb_valid     = (r_state == S_WB);
    assign bus.wb_rd        = r_rd;
    assign bus.wb_data      = r_wb_data;

    a_start_only_in_run: assert property (
        @(posedge clk) disable iff (!rst_n)
        bus.div_start |-> (r_state == S_RUN)
    );

    a_wb_hold_stable: assert property (
        @(posedge clk) disable iff (!rst_n)
        ((r_state == S_WB) && !bus.wb_ready && !bus.flush)
            |=> ($stable(r_wb_data) && $stable(r_rd) && (r_state == S_WB))
    );

endmodule

`default_nettype wire
